// File: rtl/spi_adc_responder_pkg.sv
// Shared definitions for the ADC-emulating SPI responder and the controller that reads it.
package spi_adc_responder_pkg;

  localparam int ADC_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } resp_state_t;

endpackage

// File: rtl/spi_adc_responder_sync_edge_detect.sv
// Optional synchronizer chain followed by an edge register; reports rising/falling edges
// of one SPI control line in the clk domain.
module sync_edge_detect
  import spi_adc_responder_pkg::*;
#(
  parameter int   SYNC_STAGES = 0,
  parameter logic EDGE_RESET  = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic level;
  logic edge_reg;
  logic seen_high_reg;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign level = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      always_ff @(posedge clk) begin
        if (srst) begin
          sync_reg <= '0;
        end else begin
          sync_reg[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
          end
        end
      end
      assign level = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      edge_reg      <= EDGE_RESET;
      seen_high_reg <= 1'b0;
    end else begin
      edge_reg <= level;
      if (level) seen_high_reg <= 1'b1;
    end
  end

  // A falling edge only counts once the line has been seen high since reset, so a
  // line held low through reset cannot produce a phantom edge.
  assign rise = level & ~edge_reg;
  assign fall = ~level & edge_reg & seen_high_reg;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI peripheral emulating one ADC channel: serves buffered samples MSB first whenever the
// controller frames a transfer with chip select (CPOL=0, data sampled on SPI clock rise).
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = ADC_DATA_WIDTH,
  parameter int SYNC_STAGES = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  chip_clk_in,
  input  logic                  chip_sel_in,
  output logic                  chip_data_out,
  output logic                  frame_done_out,
  output logic                  abort_out,
  output logic                  underrun_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  resp_state_t           state_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic                  fresh_reg;
  logic                  data_reg;
  logic                  frame_done_reg;
  logic                  abort_reg;
  logic                  underrun_reg;

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_RESET (1'b0)
  ) u_sck_edge (
    .clk (clk_in),
    .srst(rst_in),
    .din (chip_clk_in),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_RESET (1'b1)
  ) u_cs_edge (
    .clk (clk_in),
    .srst(rst_in),
    .din (chip_sel_in),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      hold_reg       <= '0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      fresh_reg      <= 1'b0;
      data_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      abort_reg      <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      abort_reg      <= 1'b0;
      underrun_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          data_reg <= 1'b0;
          if (cs_fall) begin
            shift_reg    <= hold_reg;
            data_reg     <= hold_reg[DATA_WIDTH-1];
            bit_cnt_reg  <= '0;
            fresh_reg    <= 1'b0;
            underrun_reg <= ~fresh_reg;
            state_reg    <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            abort_reg <= 1'b1;
            data_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (sck_rise) begin
            if (bit_cnt_reg == LAST_CNT) begin
              bit_cnt_reg    <= FULL_CNT;
              frame_done_reg <= 1'b1;
              data_reg       <= 1'b0;
              state_reg      <= WAIT_CS;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            end
          end else if (sck_fall) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
            data_reg  <= shift_reg[DATA_WIDTH-2];
          end
        end

        WAIT_CS: begin
          data_reg <= 1'b0;
          if (cs_rise) state_reg <= IDLE;
        end

        default: begin
          data_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

      // Placed last so a strobe coinciding with a frame start re-arms fresh after the
      // old buffer contents have been consumed.
      if (sample_valid_in) begin
        hold_reg  <= sample_in;
        fresh_reg <= 1'b1;
      end
    end
  end

  assign chip_data_out  = data_reg;
  assign frame_done_out = frame_done_reg;
  assign abort_out      = abort_reg;
  assign underrun_out   = underrun_reg;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: directed table, random frames against a sample/fresh model,
// and hand sequences for reset mid-frame on both a same-clock and a 2-stage-synchronized instance.
`timescale 1ns/1ps
module tb_spi_adc_responder;
  import spi_adc_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample = '0;
  logic        valid = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        dout0, done0, abort0, under0;
  logic        dout2, done2, abort2, under2;

  spi_adc_responder #(.DATA_WIDTH(16), .SYNC_STAGES(0)) dut0 (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .sample_valid_in(valid),
    .chip_clk_in(sck), .chip_sel_in(cs), .chip_data_out(dout0),
    .frame_done_out(done0), .abort_out(abort0), .underrun_out(under0)
  );

  spi_adc_responder #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut2 (
    .clk_in(clk), .rst_in(rst), .sample_in(sample), .sample_valid_in(valid),
    .chip_clk_in(sck), .chip_sel_in(cs), .chip_data_out(dout2),
    .frame_done_out(done2), .abort_out(abort2), .underrun_out(under2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int fall_cyc = 0;
  int done_cnt[2]  = '{0, 0};
  int abort_cnt[2] = '{0, 0};
  int under_cnt[2] = '{0, 0};
  int under_cyc[2] = '{0, 0};

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse monitors count high cycles, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (done0)  done_cnt[0]++;
    if (abort0) abort_cnt[0]++;
    if (under0) begin under_cnt[0]++; under_cyc[0] = cycle; end
    if (done2)  done_cnt[1]++;
    if (abort2) abort_cnt[1]++;
    if (under2) begin under_cnt[1]++; under_cyc[1] = cycle; end
  end

  // Reference model: the buffered sample and whether it has been served yet.
  logic [15:0] m_buf = '0;
  bit          m_fresh = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    sample = v;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
    m_buf  = v;
    m_fresh = 1'b1;
  endtask

  // Expected read word (n bits, right-aligned) and pulse counts {done, abort, underrun}.
  task automatic model_frame(input int n, input bit co, input logic [15:0] cov,
                             output logic [31:0] erd, output logic [11:0] ep);
    erd = '0;
    for (int i = 0; i < n; i++) erd = {erd[30:0], (i < 16) ? m_buf[15-i] : 1'b0};
    ep = {4'(n >= 16), 4'(n < 16), 4'(!m_fresh)};
    m_fresh = 1'b0;
    if (co) begin
      m_buf   = cov;
      m_fresh = 1'b1;
    end
  endtask

  task automatic run_frame(input int n, input int half, input bit co, input logic [15:0] cov,
                           output logic [31:0] rd0, output logic [31:0] rd2,
                           output logic [11:0] p0, output logic [11:0] p2,
                           output logic idle0, output logic idle2);
    int d0, a0, u0, d2, a2, u2;
    d0 = done_cnt[0]; a0 = abort_cnt[0]; u0 = under_cnt[0];
    d2 = done_cnt[1]; a2 = abort_cnt[1]; u2 = under_cnt[1];
    rd0 = '0;
    rd2 = '0;
    @(negedge clk);
    #2;
    cs = 1'b0;
    fall_cyc = cycle;
    if (co) begin
      sample = cov;
      valid  = 1'b1;
      @(negedge clk);
      valid  = 1'b0;
      #(half - 8);
    end else begin
      #(half);
    end
    for (int i = 0; i < n; i++) begin
      rd0 = {rd0[30:0], dout0};
      rd2 = {rd2[30:0], dout2};
      sck = 1'b1;
      #(half);
      sck = 1'b0;
      #(half);
    end
    cs = 1'b1;
    #(half);
    idle0 = dout0;
    idle2 = dout2;
    #(half);
    p0 = {4'(done_cnt[0] - d0), 4'(abort_cnt[0] - a0), 4'(under_cnt[0] - u0)};
    p2 = {4'(done_cnt[1] - d2), 4'(abort_cnt[1] - a2), 4'(under_cnt[1] - u2)};
  endtask

  typedef struct {
    bit          pre;
    logic [15:0] pre_val;
    bit          co;
    logic [15:0] co_val;
    int          n;
    logic [31:0] exp_rd;
    logic [11:0] exp_p;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] rd0, rd2, erd;
    logic [11:0] p0, p2, ep;
    logic        idle0, idle2;
    bit          co;
    int          n;
    logic [15:0] v, cov;

    tbl[0] = '{1, 16'hA5C3, 0, 16'h0000, 16, 32'h0000A5C3, 12'h100};  // loopback
    tbl[1] = '{0, 16'h0000, 0, 16'h0000, 16, 32'h0000A5C3, 12'h101};  // underrun repeat
    tbl[2] = '{1, 16'h5A5A, 0, 16'h0000,  7, 32'h0000002D, 12'h010};  // abort after 7
    tbl[3] = '{1, 16'h0001, 0, 16'h0000, 16, 32'h00000001, 12'h100};
    tbl[4] = '{1, 16'h1234, 1, 16'hBEEF, 16, 32'h00001234, 12'h100};  // same-cycle strobe
    tbl[5] = '{0, 16'h0000, 0, 16'h0000, 16, 32'h0000BEEF, 12'h100};
    tbl[6] = '{1, 16'h3C96, 0, 16'h0000, 20, 32'h0003C960, 12'h100};  // extra clocks
    tbl[7] = '{0, 16'h0000, 0, 16'h0000,  0, 32'h00000000, 12'h011};  // empty window

    // Phase 1: same-clock instance, 20 MHz SPI
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs0", {dout0, done0, abort0, under0}, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre) strobe(tbl[i].pre_val);
      model_frame(tbl[i].n, tbl[i].co, tbl[i].co_val, erd, ep);
      run_frame(tbl[i].n, 25, tbl[i].co, tbl[i].co_val, rd0, rd2, p0, p2, idle0, idle2);
      $display("tbl[%0d] n=%0d read=%h pulses=%h", i, tbl[i].n, rd0, p0);
      check("tbl_read", rd0, tbl[i].exp_rd);
      check("tbl_pulses", p0, tbl[i].exp_p);
      check("tbl_idle_data", idle0, 1'b0);
      if (tbl[i].exp_p[0]) check("tbl_underrun_latency", under_cyc[0] - fall_cyc, 1);
    end

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) strobe(16'($urandom));
      co  = ($urandom_range(0, 3) == 0);
      cov = 16'($urandom);
      n   = $urandom_range(0, 20);
      model_frame(n, co, cov, erd, ep);
      run_frame(n, 25, co, cov, rd0, rd2, p0, p2, idle0, idle2);
      $display("rand[%0d] n=%0d co=%0d read=%h pulses=%h", i, n, co, rd0, p0);
      check("rand_read", rd0, erd);
      check("rand_pulses", p0, ep);
      check("rand_idle_data", idle0, 1'b0);
    end

    // Phase 2: both instances, 10 MHz SPI
    @(negedge clk);
    rst = 1'b1;
    cs  = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_buf = '0;
    m_fresh = 1'b0;
    @(negedge clk);
    check("reset_outputs_both", {dout0, done0, abort0, under0, dout2, done2, abort2, under2}, 8'h00);

    strobe(16'hA5C3);
    model_frame(16, 0, 16'h0, erd, ep);
    run_frame(16, 50, 0, 16'h0, rd0, rd2, p0, p2, idle0, idle2);
    $display("sync2 frame read0=%h read2=%h", rd0, rd2);
    check("s2_read0", rd0, 32'h0000A5C3);
    check("s2_read2", rd2, 32'h0000A5C3);
    check("s2_pulses", {p0, p2}, {12'h100, 12'h100});

    model_frame(16, 0, 16'h0, erd, ep);
    run_frame(16, 50, 0, 16'h0, rd0, rd2, p0, p2, idle0, idle2);
    $display("sync2 underrun frame read0=%h read2=%h", rd0, rd2);
    check("s2_under_read", {rd0, rd2}, {32'h0000A5C3, 32'h0000A5C3});
    check("s2_under_pulses", {p0, p2}, {12'h101, 12'h101});
    check("s2_under_latency0", under_cyc[0] - fall_cyc, 1);
    check("s2_under_latency2", under_cyc[1] - fall_cyc, 3);

    // Reset after bit 5 with CS held low
    strobe(16'h0F0F);
    @(negedge clk);
    #2;
    cs = 1'b0;
    #50;
    for (int i = 0; i < 5; i++) begin
      sck = 1'b1; #50;
      sck = 1'b0; #50;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {dout0, done0, abort0, under0, dout2, done2, abort2, under2}, 8'h00);
    rst = 1'b0;
    m_buf = '0;
    m_fresh = 1'b0;
    begin
      int d0, a0, u0, d2, a2, u2;
      d0 = done_cnt[0]; a0 = abort_cnt[0]; u0 = under_cnt[0];
      d2 = done_cnt[1]; a2 = abort_cnt[1]; u2 = under_cnt[1];
      rd0 = '0;
      rd2 = '0;
      #50;
      for (int i = 0; i < 4; i++) begin
        rd0 = {rd0[30:0], dout0};
        rd2 = {rd2[30:0], dout2};
        sck = 1'b1; #50;
        sck = 1'b0; #50;
      end
      $display("post-reset cs-low window read0=%h read2=%h", rd0, rd2);
      check("postreset_no_frame_data", {rd0, rd2}, 64'h0);
      check("postreset_no_pulses",
            (done_cnt[0] - d0) + (abort_cnt[0] - a0) + (under_cnt[0] - u0) +
            (done_cnt[1] - d2) + (abort_cnt[1] - a2) + (under_cnt[1] - u2), 0);
    end
    cs = 1'b1;
    #100;
    strobe(16'h9E37);
    model_frame(16, 0, 16'h0, erd, ep);
    run_frame(16, 50, 0, 16'h0, rd0, rd2, p0, p2, idle0, idle2);
    $display("restart frame read0=%h read2=%h", rd0, rd2);
    check("restart_read", {rd0, rd2}, {32'h00009E37, 32'h00009E37});
    check("restart_pulses", {p0, p2}, {12'h100, 12'h100});
    check("restart_idle", {idle0, idle2}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
